// File: rtl/bcd_serial_subtractor.sv
// bcd_serial_subtractor
//   Digit-serial packed-BCD subtractor, diff = a - b, one decimal digit per
//   clock, least-significant digit first. A start/busy/done handshake allows
//   one operation in flight at a time. Results feed the 7-segment decoders.
//
//   Optional feature macro: BCD_SUB_SIGNMAG_EN
//     undefined : a < b yields the ten's complement with borrow_o = 1
//     defined   : a < b yields |a - b| with neg_o = 1 (extra FIX pass)
//
//   Ports
//     clk_i      clock, all state updates on posedge
//     reset_i    synchronous active-high reset
//     start_i    request, sampled only while idle
//     a_i, b_i   minuend / subtrahend, packed BCD, digit 0 in [3:0]
//     busy_o     high in every state except IDLE
//     done_o     one-cycle pulse, result valid
//     diff_o     result, packed BCD, held until the next done
//     borrow_o   final borrow out of the MSD, held with diff_o
//     invalid_o  an operand digit was > 9, held with diff_o
//     neg_o      (macro only) diff_o is a magnitude of a negative result
//
//   state  | meaning
//   IDLE   | waiting for start
//   SUB    | subtracting one digit per cycle
//   FIX    | (macro only) converting ten's complement to magnitude
//   DONE   | one-cycle result strobe

module bcd_serial_subtractor #(
  parameter int DIGITS = 2,
  localparam int W = 4 * DIGITS
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] diff_o,
  output logic         borrow_o,
  output logic         invalid_o
`ifdef BCD_SUB_SIGNMAG_EN
  ,
  output logic         neg_o
`endif
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_DONE = 2'd2
`ifdef BCD_SUB_SIGNMAG_EN
    ,
    S_FIX  = 2'd3
`endif
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           br_q, br_d;
  logic [W-1:0]   diff_q, diff_d;
  logic           borrow_q, borrow_d, invalid_q, invalid_d;
  logic           bad_digit;
  logic [4:0]     sub_r;
`ifdef BCD_SUB_SIGNMAG_EN
  logic           neg_q, neg_d;
  logic [4:0]     fix_r;
`endif

  // Returns {borrow_out, digit}; the 5-bit difference is negative exactly
  // when bit 4 is set, and adding 10 mod 16 restores a valid BCD digit.
  function automatic logic [4:0] digit_sub(input logic [3:0] x,
                                           input logic [3:0] y,
                                           input logic       bin);
    logic [4:0] t;
    t = {1'b0, x} - {1'b0, y} - {4'b0000, bin};
    if (t[4]) return {1'b1, t[3:0] + 4'd10};
    else      return {1'b0, t[3:0]};
  endfunction

  // New digits enter at the top so after DIGITS shifts digit 0 sits in [3:0].
  function automatic logic [W-1:0] shift_in(input logic [W-1:0] r,
                                            input logic [3:0]   d);
    return (r >> 4) | (W'(d) << (W - 4));
  endfunction

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a_i[4*i +: 4] > 4'd9 || b_i[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  assign sub_r = digit_sub(a_q[3:0], b_q[3:0], br_q);
`ifdef BCD_SUB_SIGNMAG_EN
  assign fix_r = digit_sub(4'd0, res_q[3:0], br_q);
`endif

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    idx_d     = idx_q;
    br_d      = br_q;
    diff_d    = diff_q;
    borrow_d  = borrow_q;
    invalid_d = invalid_q;
`ifdef BCD_SUB_SIGNMAG_EN
    neg_d     = neg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_d   = a_i;
          b_d   = b_i;
          res_d = '0;
          idx_d = IW'(DIGITS - 1);
          br_d  = 1'b0;
          if (bad_digit) begin
            state_d   = S_DONE;
            diff_d    = '0;
            borrow_d  = 1'b0;
            invalid_d = 1'b1;
`ifdef BCD_SUB_SIGNMAG_EN
            neg_d     = 1'b0;
`endif
          end else begin
            state_d = S_SUB;
          end
        end
      end
      S_SUB: begin
        a_d   = a_q >> 4;
        b_d   = b_q >> 4;
        res_d = shift_in(res_q, sub_r[3:0]);
        br_d  = sub_r[4];
        idx_d = idx_q - 1'b1;
        if (idx_q == '0) begin
`ifdef BCD_SUB_SIGNMAG_EN
          if (sub_r[4]) begin
            state_d = S_FIX;
            idx_d   = IW'(DIGITS - 1);
            br_d    = 1'b0;
          end else begin
            state_d   = S_DONE;
            diff_d    = res_d;
            borrow_d  = 1'b0;
            invalid_d = 1'b0;
            neg_d     = 1'b0;
          end
`else
          state_d   = S_DONE;
          diff_d    = res_d;
          borrow_d  = sub_r[4];
          invalid_d = 1'b0;
`endif
        end
      end
`ifdef BCD_SUB_SIGNMAG_EN
      S_FIX: begin
        res_d = shift_in(res_q, fix_r[3:0]);
        br_d  = fix_r[4];
        idx_d = idx_q - 1'b1;
        if (idx_q == '0) begin
          state_d   = S_DONE;
          diff_d    = res_d;
          borrow_d  = 1'b1;
          invalid_d = 1'b0;
          neg_d     = 1'b1;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      idx_q     <= '0;
      br_q      <= 1'b0;
      diff_q    <= '0;
      borrow_q  <= 1'b0;
      invalid_q <= 1'b0;
`ifdef BCD_SUB_SIGNMAG_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      idx_q     <= idx_d;
      br_q      <= br_d;
      diff_q    <= diff_d;
      borrow_q  <= borrow_d;
      invalid_q <= invalid_d;
`ifdef BCD_SUB_SIGNMAG_EN
      neg_q     <= neg_d;
`endif
    end
  end

  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = (state_q == S_DONE);
  assign diff_o    = diff_q;
  assign borrow_o  = borrow_q;
  assign invalid_o = invalid_q;
`ifdef BCD_SUB_SIGNMAG_EN
  assign neg_o     = neg_q;
`endif

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// tb_bcd_serial_subtractor
//   Directed self-checking bench for bcd_serial_subtractor with DIGITS = 2.
//   Honours BCD_SUB_SIGNMAG_EN for the expected results and the neg port.

module tb_bcd_serial_subtractor;
  localparam int DIGITS = 2;
  localparam int W = 4 * DIGITS;

`ifdef BCD_SUB_SIGNMAG_EN
  localparam int NEG_LAT = DIGITS + 1 + DIGITS;
`else
  localparam int NEG_LAT = DIGITS + 1;
`endif
  localparam int POS_LAT = DIGITS + 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow, invalid;
  logic [W-1:0] diff;
`ifdef BCD_SUB_SIGNMAG_EN
  logic         neg;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int lat;
  int ndone;

  always #5 clk = ~clk;

  bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .start_i   (start),
    .a_i       (a),
    .b_i       (b),
    .busy_o    (busy),
    .done_o    (done),
    .diff_o    (diff),
    .borrow_o  (borrow),
    .invalid_o (invalid)
`ifdef BCD_SUB_SIGNMAG_EN
    ,
    .neg_o     (neg)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start an operation, wait (bounded) for done, then step into the
  // following idle cycle so a next call starts back-to-back.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, output int l);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    l = 1;
    while (done !== 1'b1 && l < 20) begin
      @(posedge clk); #1;
      l++;
    end
    @(posedge clk); #1;
    chk("done_single_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_diff", {24'd0, diff}, 32'h00);
    chk("rst_borrow", {31'd0, borrow}, 32'd0);
    chk("rst_invalid", {31'd0, invalid}, 32'd0);
`ifdef BCD_SUB_SIGNMAG_EN
    chk("rst_neg", {31'd0, neg}, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // 45 - 23, cycle-accurate handshake
    @(negedge clk);
    a = 8'h45; b = 8'h23; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t1_busy_T1", {31'd0, busy}, 32'd1);
    chk("t1_done_T1", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    chk("t1_busy_T2", {31'd0, busy}, 32'd1);
    chk("t1_done_T2", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    chk("t1_busy_T3", {31'd0, busy}, 32'd1);
    chk("t1_done_T3", {31'd0, done}, 32'd1);
    chk("t1_diff", {24'd0, diff}, 32'h22);
    chk("t1_borrow", {31'd0, borrow}, 32'd0);
    chk("t1_invalid", {31'd0, invalid}, 32'd0);
    @(posedge clk); #1;
    chk("t1_busy_T4", {31'd0, busy}, 32'd0);
    chk("t1_done_T4", {31'd0, done}, 32'd0);
    chk("t1_diff_held", {24'd0, diff}, 32'h22);

    // internal borrow chain
    run_op(8'h30, 8'h07, lat);
    chk("t2a_lat", lat, POS_LAT);
    chk("t2a_diff", {24'd0, diff}, 32'h23);
    chk("t2a_borrow", {31'd0, borrow}, 32'd0);

    run_op(8'h99, 8'h99, lat);
    chk("t2b_lat", lat, POS_LAT);
    chk("t2b_diff", {24'd0, diff}, 32'h00);
    chk("t2b_borrow", {31'd0, borrow}, 32'd0);

    // negative result
    run_op(8'h12, 8'h45, lat);
    chk("t3_lat", lat, NEG_LAT);
    chk("t3_borrow", {31'd0, borrow}, 32'd1);
`ifdef BCD_SUB_SIGNMAG_EN
    chk("t3_diff", {24'd0, diff}, 32'h33);
    chk("t3_neg", {31'd0, neg}, 32'd1);
`else
    chk("t3_diff", {24'd0, diff}, 32'h67);
`endif

    // invalid operand digit, then back-to-back valid op
    run_op(8'h1A, 8'h05, lat);
    chk("t4a_lat", lat, 1);
    chk("t4a_invalid", {31'd0, invalid}, 32'd1);
    chk("t4a_diff", {24'd0, diff}, 32'h00);
    chk("t4a_borrow", {31'd0, borrow}, 32'd0);
`ifdef BCD_SUB_SIGNMAG_EN
    chk("t4a_neg", {31'd0, neg}, 32'd0);
`endif
    run_op(8'h09, 8'h01, lat);
    chk("t4b_lat", lat, POS_LAT);
    chk("t4b_diff", {24'd0, diff}, 32'h08);
    chk("t4b_invalid", {31'd0, invalid}, 32'd0);

    // start held high while busy, operands changed after T
    @(negedge clk);
    a = 8'h45; b = 8'h23; start = 1'b1;
    @(posedge clk); #1;
    a = 8'h99; b = 8'h00;
    ndone = int'(done);
    @(posedge clk); #1;
    ndone += int'(done);
    @(posedge clk); #1;
    start = 1'b0;
    ndone += int'(done);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      ndone += int'(done);
    end
    chk("t5a_done_count", ndone, 1);
    chk("t5a_diff", {24'd0, diff}, 32'h22);
    chk("t5a_busy", {31'd0, busy}, 32'd0);

    // reset mid-operation
    @(negedge clk);
    a = 8'h45; b = 8'h23; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t5b_busy", {31'd0, busy}, 32'd0);
    chk("t5b_done", {31'd0, done}, 32'd0);
    chk("t5b_diff", {24'd0, diff}, 32'h00);
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      ndone += int'(done);
    end
    chk("t5b_no_done", ndone, 0);

    run_op(8'h00, 8'h01, lat);
    chk("t5c_lat", lat, NEG_LAT);
    chk("t5c_borrow", {31'd0, borrow}, 32'd1);
`ifdef BCD_SUB_SIGNMAG_EN
    chk("t5c_diff", {24'd0, diff}, 32'h01);
    chk("t5c_neg", {31'd0, neg}, 32'd1);
`else
    chk("t5c_diff", {24'd0, diff}, 32'h99);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
